// File: rtl/cnn_pkg.sv
// Shared constants and sequencer state encoding for the CNN layer sequencer.
package cnn_pkg;

    localparam int unsigned CNN_DW          = 8;
    localparam int unsigned CNN_NUM_CLASSES = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ARGMAX = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/cnn_argmax.sv
// Streaming signed argmax over NUM_CLASSES score beats; ties keep the lowest index.
module cnn_argmax
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = CNN_NUM_CLASSES,
    parameter int unsigned DW          = CNN_DW,
    parameter int unsigned IW          = $clog2(NUM_CLASSES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 valid,
    input  logic signed [DW-1:0] data,
    output logic        [IW-1:0] best_idx_c,
    output logic signed [DW-1:0] best_val_c,
    output logic                 last_c
);

    logic        [IW-1:0] cnt_q;
    logic        [IW-1:0] idx_q;
    logic signed [DW-1:0] max_q;
    logic                 take_c;

    // First beat always seeds the maximum; later beats must be strictly greater.
    assign take_c     = (cnt_q == '0) || (data > max_q);
    assign best_val_c = take_c ? data  : max_q;
    assign best_idx_c = take_c ? cnt_q : idx_q;
    assign last_c     = valid && (cnt_q == IW'(NUM_CLASSES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            max_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (valid) begin
            cnt_q <= last_c ? '0 : cnt_q + IW'(1);
            idx_q <= best_idx_c;
            max_q <= best_val_c;
        end
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Launches conv/pool layers in order, ping-pongs the feature-map bank, then argmaxes the scores.
// Optional per-layer watchdog enabled by defining CNN_SEQ_WDOG_EN.
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_LAYERS  = 2,
    parameter int unsigned NUM_CLASSES = CNN_NUM_CLASSES,
    parameter int unsigned DW          = CNN_DW,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic        [NUM_LAYERS-1:0]         layer_start,
    input  logic        [NUM_LAYERS-1:0]         layer_done,
    output logic                                 bank_sel,
    input  logic                                 score_valid,
    input  logic signed [DW-1:0]                 score_data,
    output logic                                 busy,
    output logic                                 class_valid,
    output logic        [$clog2(NUM_CLASSES)-1:0] class_idx,
    output logic signed [DW-1:0]                 class_score,
    output logic                                 err
);

    localparam int unsigned IW  = $clog2(NUM_CLASSES);
    localparam int unsigned LIW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    seq_state_e           state_q, state_d;
    logic       [LIW-1:0] li_q, li_d;
    logic [NUM_LAYERS-1:0] layer_start_d;
    logic                 bank_d, busy_d, class_valid_d;
    logic        [IW-1:0] class_idx_d;
    logic signed [DW-1:0] class_score_d;

    logic                 accept_c;
    logic                 beat_c;
    logic                 wdog_hit_c;
    logic        [IW-1:0] best_idx_c;
    logic signed [DW-1:0] best_val_c;
    logic                 last_c;

    assign accept_c = (state_q == ST_IDLE) && start;
    assign beat_c   = (state_q == ST_ARGMAX) && score_valid;

    cnn_argmax #(
        .NUM_CLASSES (NUM_CLASSES),
        .DW          (DW),
        .IW          (IW)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept_c),
        .valid      (beat_c),
        .data       (score_data),
        .best_idx_c (best_idx_c),
        .best_val_c (best_val_c),
        .last_c     (last_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            li_q        <= '0;
            bank_sel    <= 1'b0;
            layer_start <= '0;
            busy        <= 1'b0;
            class_valid <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
        end else begin
            state_q     <= state_d;
            li_q        <= li_d;
            bank_sel    <= bank_d;
            layer_start <= layer_start_d;
            busy        <= busy_d;
            class_valid <= class_valid_d;
            class_idx   <= class_idx_d;
            class_score <= class_score_d;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d       = state_q;
        li_d          = li_q;
        bank_d        = bank_sel;
        layer_start_d = '0;
        busy_d        = busy;
        class_valid_d = 1'b0;
        class_idx_d   = class_idx;
        class_score_d = class_score;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_LAUNCH;
                    li_d          = '0;
                    bank_d        = 1'b0;
                    layer_start_d = NUM_LAYERS'(1);
                    busy_d        = 1'b1;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (layer_done[li_q]) begin
                    bank_d = ~bank_sel;
                    if (li_q == LIW'(NUM_LAYERS - 1)) begin
                        state_d = ST_ARGMAX;
                    end else begin
                        li_d          = li_q + LIW'(1);
                        layer_start_d = NUM_LAYERS'(1) << (li_q + LIW'(1));
                        state_d       = ST_LAUNCH;
                    end
                end else if (wdog_hit_c) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_ARGMAX: begin
                if (last_c) begin
                    state_d       = ST_DONE;
                    class_valid_d = 1'b1;
                    class_idx_d   = best_idx_c;
                    class_score_d = best_val_c;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

`ifdef CNN_SEQ_WDOG_EN
    localparam int unsigned WCW = $clog2(WDOG_CYCLES + 1);

    logic [WCW-1:0] wdog_q;

    assign wdog_hit_c = (wdog_q == WCW'(WDOG_CYCLES - 1));

    // Counts consecutive cycles spent waiting on the current layer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
            err    <= 1'b0;
        end else begin
            if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
                wdog_q <= wdog_q + WCW'(1);
            end else begin
                wdog_q <= '0;
            end
            if (accept_c) begin
                err <= 1'b0;
            end else if ((state_q == ST_WAIT) && (state_d == ST_IDLE)) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_wdog;

    assign unused_wdog = 32'(WDOG_CYCLES);
    assign wdog_hit_c  = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: layer sequencing, argmax, ignore rules, reset abort, watchdog.
module tb_cnn_layer_sequencer;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        layer_start;
    logic [1:0]        layer_done;
    logic              bank_sel;
    logic              score_valid;
    logic signed [7:0] score_data;
    logic              busy;
    logic              class_valid;
    logic [3:0]        class_idx;
    logic signed [7:0] class_score;
    logic              err;

    int                pass_cnt = 0;
    int                chk_cnt  = 0;
    int                cyc      = 0;
    logic signed [7:0] sc [10];

    cnn_layer_sequencer #(
        .NUM_LAYERS  (2),
        .NUM_CLASSES (10),
        .DW          (8),
        .WDOG_CYCLES (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .layer_start (layer_start),
        .layer_done  (layer_done),
        .bank_sel    (bank_sel),
        .score_valid (score_valid),
        .score_data  (score_data),
        .busy        (busy),
        .class_valid (class_valid),
        .class_idx   (class_idx),
        .class_score (class_score),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_scores(input logic [79:0] v);
        for (int i = 0; i < 10; i++) sc[i] = v[79-8*i -: 8];
    endtask

    // Full inference: done[0] at cycle 10, done[1] at cycle 30, beats on cycles 31..40.
    task automatic run(input string tag, input bit inj, input bit inj_beat,
                       input logic [3:0] exp_idx, input logic [7:0] exp_sc);
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
        check({tag, "_ls0"}, 32'(layer_start), 32'h1);
        check({tag, "_busy"}, 32'(busy), 32'h1);
        check({tag, "_bank0"}, 32'(bank_sel), 32'h0);
        step();
        check({tag, "_ls_off"}, 32'(layer_start), 32'h0);
        while (cyc < 5) step();
        if (inj) begin
            start      = 1'b1;
            layer_done = 2'b10;
        end
        step();
        start      = 1'b0;
        layer_done = 2'b00;
        check({tag, "_ignore"}, {28'h0, bank_sel, layer_start, busy}, 32'h1);
        while (cyc < 10) step();
        layer_done = 2'b01;
        step();
        layer_done = 2'b00;
        check({tag, "_ls1"}, 32'(layer_start), 32'h2);
        check({tag, "_bank1"}, 32'(bank_sel), 32'h1);
        while (cyc < 15) step();
        if (inj_beat) begin
            score_valid = 1'b1;
            score_data  = 8'sd50;
        end
        step();
        score_valid = 1'b0;
        while (cyc < 30) step();
        layer_done = 2'b10;
        step();
        layer_done = 2'b00;
        check({tag, "_ls_end"}, {29'h0, layer_start, bank_sel}, 32'h0);
        check({tag, "_busy_am"}, {30'h0, busy, class_valid}, 32'h2);
        for (int i = 0; i < 10; i++) begin
            score_valid = 1'b1;
            score_data  = sc[i];
            step();
        end
        score_valid = 1'b0;
        check({tag, "_cv"}, 32'(class_valid), 32'h1);
        check({tag, "_idx"}, 32'(class_idx), 32'(exp_idx));
        check({tag, "_score"}, {24'h0, class_score}, {24'h0, exp_sc});
        step();
        check({tag, "_cv_off"}, {30'h0, class_valid, busy}, 32'h0);
        check({tag, "_held"}, {20'h0, class_idx, class_score}, {20'h0, exp_idx, exp_sc});
        check({tag, "_err"}, 32'(err), 32'h0);
    endtask

    initial begin
        logic cv_seen;
        rst         = 1'b0;
        start       = 1'b0;
        layer_done  = 2'b00;
        score_valid = 1'b0;
        score_data  = '0;
        repeat (3) step();
        check("rst_outs", {11'h0, layer_start, bank_sel, busy, class_valid, class_idx, class_score, err},
              32'h0);
        rst = 1'b1;
        step();

        set_scores({8'sd3, -8'sd5, 8'sd9, 8'sd9, 8'sd0, -8'sd128, 8'sd127, 8'sd2, 8'sd1, 8'sd7});
        run("r1", 1'b0, 1'b0, 4'd6, 8'h7f);
        step();
        set_scores({-8'sd3, -8'sd1, -8'sd7, -8'sd1, -8'sd2, -8'sd9, -8'sd100, -8'sd1, -8'sd50, -8'sd4});
        run("r2", 1'b1, 1'b0, 4'd1, 8'hff);
        step();
        set_scores({10{8'h80}});
        run("r3", 1'b1, 1'b1, 4'd0, 8'h80);
        step();

        // Abort mid-argmax with an asynchronous reset.
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
        step();
        step();
        layer_done = 2'b01;
        step();
        layer_done = 2'b00;
        step();
        step();
        layer_done = 2'b10;
        step();
        layer_done = 2'b00;
        for (int i = 0; i < 4; i++) begin
            score_valid = 1'b1;
            score_data  = 8'sd20;
            step();
        end
        check("ab_busy_pre", 32'(busy), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("ab_outs", {11'h0, layer_start, bank_sel, busy, class_valid, class_idx, class_score, err},
              32'h0);
        cv_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) rst = 1'b1;
            step();
            cv_seen |= class_valid;
        end
        score_valid = 1'b0;
        check("ab_no_cv", 32'(cv_seen), 32'h0);
        check("ab_idle", 32'(busy), 32'h0);
        set_scores({8'sd3, -8'sd5, 8'sd9, 8'sd9, 8'sd0, -8'sd128, 8'sd127, 8'sd2, 8'sd1, 8'sd7});
        run("r4", 1'b0, 1'b0, 4'd6, 8'h7f);
        step();

`ifdef CNN_SEQ_WDOG_EN
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
        while (cyc < 101) step();
        check("wd_before", {30'h0, busy, err}, 32'h2);
        step();
        check("wd_err", {30'h0, busy, err}, 32'h1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("wd_clear", {30'h0, busy, err}, 32'h2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
